// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: load alignment and extension, writeback mux, forwarding tap and saturating retire counter.
// Latency 1 cycle; stall holds every register, and flush overrides stall.
module mem_wb_stage_reg #(
  parameter int XLEN         = 64,
  parameter int REG_ADDR_W   = 5,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic                    RegWrite,
  input  logic                    MemtoReg,
  input  logic [2:0]              funct3,
  input  logic [XLEN-1:0]         Read_Data_Memory,
  input  logic [XLEN-1:0]         Result,
  input  logic [REG_ADDR_W-1:0]   RD,
  output logic                    valid_S,
  output logic                    RegWrite_S,
  output logic [REG_ADDR_W-1:0]   RD_S,
  output logic [XLEN-1:0]         WB_Data_S,
  output logic                    fwd_valid,
  output logic [REG_ADDR_W-1:0]   fwd_rd,
  output logic [XLEN-1:0]         fwd_data,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  logic [2:0]      off;
  logic [63:0]     lane;
  logic [63:0]     fmt64;
  logic [XLEN-1:0] formatted;
  logic [XLEN-1:0] wb_next;
  logic            we_next;
  logic            retire;

  // Formatting is done in a 64-bit domain and truncated, so one case table serves both XLEN values.
  always_comb begin
    off   = (XLEN == 64) ? Result[2:0] : {1'b0, Result[1:0]};
    lane  = 64'(Read_Data_Memory) >> {off, 3'b000};
    fmt64 = 64'b0;
    case (funct3)
      3'b000: fmt64 = 64'($signed(lane[7:0]));
      3'b001: fmt64 = 64'($signed(lane[15:0]));
      3'b010: fmt64 = (XLEN == 64) ? 64'($signed(lane[31:0])) : {32'b0, lane[31:0]};
      3'b011: fmt64 = (XLEN == 64) ? lane : 64'b0;
      3'b100: fmt64 = {56'b0, lane[7:0]};
      3'b101: fmt64 = {48'b0, lane[15:0]};
      3'b110: fmt64 = (XLEN == 64) ? {32'b0, lane[31:0]} : 64'b0;
      default: fmt64 = 64'b0;
    endcase
    formatted = fmt64[XLEN-1:0];
    wb_next   = MemtoReg ? formatted : Result;
    we_next   = valid_in & RegWrite & (RD != '0);
    // A departing instruction has retired even if the same edge flushes the stage.
    retire    = valid_S & (~stall | flush);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_S      <= 1'b0;
      RegWrite_S   <= 1'b0;
      RD_S         <= '0;
      WB_Data_S    <= '0;
      retire_count <= '0;
    end else begin
      if (flush) begin
        valid_S    <= 1'b0;
        RegWrite_S <= 1'b0;
        RD_S       <= '0;
        WB_Data_S  <= '0;
      end else if (!stall) begin
        valid_S    <= valid_in;
        RegWrite_S <= we_next;
        RD_S       <= RD;
        WB_Data_S  <= wb_next;
      end
      if (retire && (retire_count != '1))
        retire_count <= retire_count + RETIRE_CNT_W'(1);
    end
  end

  assign fwd_valid = RegWrite_S;
  assign fwd_rd    = RD_S;
  assign fwd_data  = WB_Data_S;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Randomized bench for mem_wb_stage_reg against a byte-level reference model of the WB stage.
module tb_mem_wb_stage_reg;

  logic        clk = 1'b0;
  logic        reset_n, stall, flush, valid_in, RegWrite, MemtoReg;
  logic [2:0]  funct3;
  logic [63:0] Read_Data_Memory, Result;
  logic [4:0]  RD;
  logic        valid_S, RegWrite_S, fwd_valid;
  logic [4:0]  RD_S, fwd_rd;
  logic [63:0] WB_Data_S, fwd_data;
  logic [3:0]  retire_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid = 1'b0, m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_wb = '0;
  logic [3:0]  m_cnt = '0;

  mem_wb_stage_reg #(.XLEN(64), .REG_ADDR_W(5), .RETIRE_CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .valid_in(valid_in), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .funct3(funct3),
    .Read_Data_Memory(Read_Data_Memory), .Result(Result), .RD(RD),
    .valid_S(valid_S), .RegWrite_S(RegWrite_S), .RD_S(RD_S), .WB_Data_S(WB_Data_S),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Load result built by picking bytes out of the doubleword one at a time.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] data,
                                           input logic [63:0] addr);
    int          off;
    int          n;
    bit          sgn;
    logic [63:0] r;
    off = int'(addr[2:0]);
    case (f3)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: begin n = 4; sgn = 1; end
      3'd3: begin n = 8; sgn = 0; end
      3'd4: begin n = 1; sgn = 0; end
      3'd5: begin n = 2; sgn = 0; end
      3'd6: begin n = 4; sgn = 0; end
      default: return 64'd0;
    endcase
    r = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = data[8*(off+i) +: 8];
    if (sgn && r[8*n-1])
      for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  // One rising edge: advance the model from the inputs present at the edge, then settle.
  task automatic cycle();
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 0; m_we = 0; m_rd = '0; m_wb = '0; m_cnt = '0;
    end else begin
      if (m_valid && (!stall || flush) && m_cnt < 4'd15) m_cnt = m_cnt + 4'd1;
      if (flush) begin
        m_valid = 0; m_we = 0; m_rd = '0; m_wb = '0;
      end else if (!stall) begin
        m_valid = valid_in;
        m_we    = valid_in && RegWrite && (RD != 0);
        m_rd    = RD;
        m_wb    = MemtoReg ? ref_load(funct3, Read_Data_Memory, Result) : Result;
      end
    end
    #1;
  endtask

  task automatic rand_inputs();
    valid_in         = 1'($urandom_range(0, 1));
    RegWrite         = 1'($urandom_range(0, 1));
    MemtoReg         = 1'($urandom_range(0, 1));
    funct3           = 3'($urandom_range(0, 7));
    RD               = 5'($urandom_range(0, 31));
    Result           = {$urandom(), $urandom()};
    Read_Data_Memory = {$urandom(), $urandom()};
    if (funct3 == 3'd3) Result[2:0] = 3'd0;
  endtask

  task automatic do_reset();
    reset_n = 0; stall = 0; flush = 0;
    cycle();
    reset_n = 1;
  endtask

  task automatic test_reset();
    rand_inputs(); valid_in = 1; RegWrite = 1; RD = 5'd9;
    reset_n = 0; stall = 0; flush = 0;
    cycle();
    rand_inputs(); valid_in = 1;
    cycle();
    checks++;
    if ({valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count, fwd_valid, fwd_rd, fwd_data} !== '0) begin
      errors++;
      $display("FAIL reset_zero: got valid=%b we=%b rd=%0d wb=%h cnt=%0d fwd=%b/%0d/%h, expected all 0",
               valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count, fwd_valid, fwd_rd, fwd_data);
    end
    reset_n = 1; valid_in = 1; RegWrite = 1; MemtoReg = 0; RD = 5'd5; Result = 64'h1234;
    cycle();
    checks++;
    if (RD_S !== 5'd5) begin errors++; $display("FAIL reset_first_rd: got %0d expected 5", RD_S); end
    checks++;
    if (WB_Data_S !== 64'h1234) begin errors++; $display("FAIL reset_first_wb: got %h expected 1234", WB_Data_S); end
    checks++;
    if (RegWrite_S !== 1'b1 || valid_S !== 1'b1) begin
      errors++; $display("FAIL reset_first_we: got we=%b valid=%b expected 1/1", RegWrite_S, valid_S);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b011};
    logic [63:0] adr [5] = '{64'h1007, 64'h1007, 64'h1004, 64'h1004, 64'h1000};
    logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_8070_6050,
                             64'h8070_6050, 64'h8070_6050_4030_2010};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1; RegWrite = 1; MemtoReg = 1; RD = 5'd7;
      funct3 = f3[i]; Result = adr[i]; Read_Data_Memory = 64'h8070_6050_4030_2010;
      cycle();
      checks++;
      if (WB_Data_S !== exp[i] || fwd_data !== exp[i]) begin
        errors++;
        $display("FAIL load_ext[%0d] f3=%b: got wb=%h fwd=%h expected %h", i, f3[i], WB_Data_S, fwd_data, exp[i]);
      end
    end
  endtask

  task automatic test_x0();
    do_reset();
    valid_in = 1; RegWrite = 1; RD = 5'd0; MemtoReg = 0; Result = {$urandom(), $urandom()};
    cycle();
    checks++;
    if (RegWrite_S !== 1'b0 || fwd_valid !== 1'b0 || valid_S !== 1'b1 || retire_count !== 4'd0) begin
      errors++;
      $display("FAIL x0_suppress: got we=%b fwd_valid=%b valid=%b cnt=%0d expected 0/0/1/0",
               RegWrite_S, fwd_valid, valid_S, retire_count);
    end
    valid_in = 0;
    cycle();
    checks++;
    if (retire_count !== 4'd1) begin
      errors++; $display("FAIL x0_retire: got cnt=%0d expected 1", retire_count);
    end
  endtask

  task automatic test_stall();
    logic [74:0] snap;
    logic [63:0] exp_wb;
    do_reset();
    rand_inputs(); valid_in = 1;
    cycle();
    snap = {valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count};
    checks++;
    if (snap !== {m_valid, m_we, m_rd, m_wb, m_cnt}) begin
      errors++; $display("FAIL stall_pre: got %h expected %h", snap, {m_valid, m_we, m_rd, m_wb, m_cnt});
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle();
      checks++;
      if ({valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count} !== snap) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i,
                 {valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count}, snap);
      end
    end
    stall = 0;
    rand_inputs(); valid_in = 1; RegWrite = 1; RD = 5'd17;
    exp_wb = MemtoReg ? ref_load(funct3, Read_Data_Memory, Result) : Result;
    cycle();
    checks++;
    if ({valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count} !== {1'b1, 1'b1, 5'd17, exp_wb, 4'd1}) begin
      errors++;
      $display("FAIL stall_release: got v=%b we=%b rd=%0d wb=%h cnt=%0d expected 1/1/17/%h/1",
               valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count, exp_wb);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    rand_inputs(); valid_in = 1; RegWrite = 1; RD = 5'd3;
    cycle();
    flush = 1; stall = 1; rand_inputs(); valid_in = 1;
    cycle();
    checks++;
    if (valid_S !== 1'b0 || RegWrite_S !== 1'b0 || RD_S !== 5'd0 || WB_Data_S !== 64'd0 || retire_count !== 4'd1) begin
      errors++;
      $display("FAIL flush_stall: got v=%b we=%b rd=%0d wb=%h cnt=%0d expected 0/0/0/0/1",
               valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      rand_inputs();
      cycle();
      checks++;
      if ({valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count} !== {m_valid, m_we, m_rd, m_wb, m_cnt} ||
          {fwd_valid, fwd_rd, fwd_data} !== {m_we, m_rd, m_wb}) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b we=%b rd=%0d wb=%h cnt=%0d fwd=%b/%0d/%h expected v=%b we=%b rd=%0d wb=%h cnt=%0d",
                 i, valid_S, RegWrite_S, RD_S, WB_Data_S, retire_count, fwd_valid, fwd_rd, fwd_data,
                 m_valid, m_we, m_rd, m_wb, m_cnt);
      end
    end
    reset_n = 1; stall = 0; flush = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_inputs(); valid_in = 1;
      cycle();
    end
    checks++;
    if (retire_count !== 4'd15) begin
      errors++; $display("FAIL saturation: got cnt=%0d expected 15", retire_count);
    end
    reset_n = 0;
    cycle();
    checks++;
    if (retire_count !== 4'd0) begin
      errors++; $display("FAIL saturation_reset: got cnt=%0d expected 0", retire_count);
    end
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; stall = 0; flush = 0;
    rand_inputs();
    test_reset();
    test_load_ext();
    test_x0();
    test_stall();
    test_flush_stall();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", checks, errors);
    $finish;
  end

endmodule
